// File: rtl/main_ctrl_pkg.sv
// Shared encodings for the multicycle main controller and the ALU controller.
// Build option: MAIN_CTRL_JUMP_EN adds the JUMP state and makes opcode 000010 legal.
package main_ctrl_pkg;

    // Controller states. The encodings above the last state are unreachable
    // and recover to FETCH.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10
`ifdef MAIN_CTRL_JUMP_EN
        ,
        JUMP   = 4'd11
`endif
    } state_t;

`ifdef MAIN_CTRL_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    // Opcodes, taken from Instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp as seen by the ALU controller
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source mux
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Full control word for one state. pcwrite and branch are combined with
    // Zero in the top to form PCEn.
    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
        logic       illegalop;
    } ctrl_word_t;

    // True for opcodes this build of the controller executes
    function automatic logic opcode_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: ok = 1'b1;
            OP_J:                                    ok = JUMP_EN;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/main_ctrl_if.sv
// Controller <-> datapath signal bundle for the multicycle main controller.
// The only handshake is MemReady: the controller holds an access (FETCH,
// MEMRD, MEMWR) with its controls stable until a cycle in which the memory
// reports MemReady=1; that cycle completes the access and the FSM advances.
interface main_ctrl_if;
    logic [31:0] Instruction;
    logic        Zero;
    logic        MemReady;

    logic        IorD;
    logic        IRWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic [1:0]  ALUOp;
    logic        PCEn;
    logic        IllegalOp;

    // Controller side
    modport master (
        input  Instruction, Zero, MemReady,
        output IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
               ALUSrcB, PCSrc, ALUOp, PCEn, IllegalOp
    );

    // Datapath / memory side
    modport slave (
        output Instruction, Zero, MemReady,
        input  IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
               ALUSrcB, PCSrc, ALUOp, PCEn, IllegalOp
    );
endinterface

// File: rtl/main_ctrl_outdec.sv
// State -> control word decode for the main controller (purely combinational).
// Build option: MAIN_CTRL_JUMP_EN enables the JUMP state decode.
module main_ctrl_outdec
    import main_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       hold,       // reset in progress: FETCH muxes, no writes
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_word_t cw
);

    // Decode the current state; anything not set for a state stays 0
    always_comb begin
        cw = '0;
        if (hold) begin
            cw.alusrcb = SRCB_FOUR;
        end else begin
            case (state)
                FETCH: begin
                    cw.alusrcb = SRCB_FOUR;
                    cw.aluop   = ALUOP_ADD;
                    cw.pcsrc   = PCSRC_ALU;
                    cw.irwrite = mem_ready;
                    cw.pcwrite = mem_ready;
                end
                DECODE: begin
                    cw.alusrcb   = SRCB_IMM_SH;
                    cw.aluop     = ALUOP_ADD;
                    cw.illegalop = ~opcode_legal(opcode);
                end
                MEMADR: begin
                    cw.alusrca = 1'b1;
                    cw.alusrcb = SRCB_IMM;
                    cw.aluop   = ALUOP_ADD;
                end
                MEMRD: begin
                    cw.iord = 1'b1;
                end
                MEMWB: begin
                    cw.memtoreg = 1'b1;
                    cw.regwrite = 1'b1;
                end
                MEMWR: begin
                    cw.iord     = 1'b1;
                    cw.memwrite = 1'b1;
                end
                EXEC: begin
                    cw.alusrca = 1'b1;
                    cw.alusrcb = SRCB_REG;
                    cw.aluop   = ALUOP_FUNCT;
                end
                ALUWB: begin
                    cw.regdst   = 1'b1;
                    cw.regwrite = 1'b1;
                end
                BRANCH: begin
                    cw.alusrca = 1'b1;
                    cw.alusrcb = SRCB_REG;
                    cw.aluop   = ALUOP_SUB;
                    cw.pcsrc   = PCSRC_ALUOUT;
                    cw.branch  = 1'b1;
                end
                ADDIEX: begin
                    cw.alusrca = 1'b1;
                    cw.alusrcb = SRCB_IMM;
                    cw.aluop   = ALUOP_ADD;
                end
                ADDIWB: begin
                    cw.regwrite = 1'b1;
                end
`ifdef MAIN_CTRL_JUMP_EN
                JUMP: begin
                    cw.pcsrc   = PCSRC_JUMP;
                    cw.pcwrite = 1'b1;
                end
`endif
                default: cw = '0;
            endcase
        end
    end

endmodule

// File: rtl/main_controller.sv
// Multicycle MIPS-style main controller: state register, next-state logic,
// and the control-word decoder. The current state is exported on state_dbg.
// Build option: MAIN_CTRL_JUMP_EN adds the j instruction (JUMP state).
module main_controller
    import main_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    main_ctrl_if.master bus,
    output logic [3:0]  state_dbg
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t cw;
    logic [5:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = bus.Instruction[31:26];
    assign unused_instr_bits = ^bus.Instruction[25:0];

    // State register; reset wins over any stall
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the opcode is only looked at in DECODE and MEMADR
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (bus.MemReady) state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
`ifdef MAIN_CTRL_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                if (bus.MemReady) state_d = MEMWB;
            end
            MEMWB:   state_d = FETCH;
            MEMWR: begin
                if (bus.MemReady) state_d = FETCH;
            end
            EXEC:    state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
`ifdef MAIN_CTRL_JUMP_EN
            JUMP:    state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    main_ctrl_outdec u_outdec (
        .state     (state_q),
        .hold      (reset),
        .mem_ready (bus.MemReady),
        .opcode    (opcode),
        .cw        (cw)
    );

    // Drive the datapath; the branch term is the only use of Zero
    always_comb begin
        bus.IorD      = cw.iord;
        bus.IRWrite   = cw.irwrite;
        bus.MemWrite  = cw.memwrite;
        bus.RegWrite  = cw.regwrite;
        bus.RegDst    = cw.regdst;
        bus.MemtoReg  = cw.memtoreg;
        bus.ALUSrcA   = cw.alusrca;
        bus.ALUSrcB   = cw.alusrcb;
        bus.PCSrc     = cw.pcsrc;
        bus.ALUOp     = cw.aluop;
        bus.PCEn      = cw.pcwrite | (cw.branch & bus.Zero);
        bus.IllegalOp = cw.illegalop;
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_main_controller.sv
// Bench for main_controller: each driven cycle pushes the expected state and
// control outputs; a negedge monitor pops and compares.
module tb_main_controller;
    import main_ctrl_pkg::*;

    localparam int W = 19;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] state_dbg;

    main_ctrl_if bus ();

    main_controller dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        lbl_q[$];
    int           total = 0;
    int           bad   = 0;
    bit           mon_on   = 1'b0;
    bit           end_req  = 1'b0;
    bit           end_done = 1'b0;

    // Opcodes this build is expected to accept
    function automatic logic legal(input logic [5:0] op);
        logic ok;
        ok = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
             (op == 6'b000100) || (op == 6'b001000);
`ifdef MAIN_CTRL_JUMP_EN
        if (op == 6'b000010) ok = 1'b1;
`endif
        return ok;
    endfunction

    // Expected {state, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
    // ALUSrcA, ALUSrcB, PCSrc, ALUOp, PCEn, IllegalOp} for one cycle
    function automatic logic [W-1:0] spec_out(input state_t st, input logic rst,
                                              input logic mr, input logic z,
                                              input logic [5:0] op);
        logic       iord, irw, memw, regw, regdst, mtr, srca, pcen, ill;
        logic [1:0] srcb, pcsrc, aluop;
        logic [3:0] sv;
        sv = st;
        {iord, irw, memw, regw, regdst, mtr, srca, pcen, ill} = '0;
        srcb = 2'b00; pcsrc = 2'b00; aluop = 2'b00;
        if (rst) begin
            srcb = 2'b01;
        end else begin
            case (st)
                FETCH:  begin srcb = 2'b01; irw = mr; pcen = mr; end
                DECODE: begin srcb = 2'b11; ill = !legal(op); end
                MEMADR: begin srca = 1'b1; srcb = 2'b10; end
                MEMRD:  iord = 1'b1;
                MEMWB:  begin mtr = 1'b1; regw = 1'b1; end
                MEMWR:  begin iord = 1'b1; memw = 1'b1; end
                EXEC:   begin srca = 1'b1; aluop = 2'b10; end
                ALUWB:  begin regdst = 1'b1; regw = 1'b1; end
                BRANCH: begin srca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; pcen = z; end
                ADDIEX: begin srca = 1'b1; srcb = 2'b10; end
                ADDIWB: regw = 1'b1;
`ifdef MAIN_CTRL_JUMP_EN
                JUMP:   begin pcsrc = 2'b10; pcen = 1'b1; end
`endif
                default: ;
            endcase
        end
        return {sv, iord, irw, memw, regw, regdst, mtr, srca, srcb, pcsrc, aluop, pcen, ill};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle and record what the controller must show during it
    task automatic cycle(input state_t st, input logic mr, input logic z,
                         input logic [31:0] instr, input logic rst, input string lbl);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.MemReady    = mr;
        bus.Zero        = z;
        bus.Instruction = instr;
        exp_q.push_back(spec_out(st, rst, mr, z, instr[31:26]));
        lbl_q.push_back(lbl);
        mon_on = 1'b1;
    endtask

    // Memory wait: stalls<0 picks a random number of not-ready cycles
    task automatic mem_wait(input state_t st, input int stalls, input string lbl);
        int n;
        n = (stalls < 0) ? int'($urandom_range(0, 2)) : stalls;
        repeat (n) cycle(st, 1'b0, rbit(), $urandom(), 1'b0, lbl);
        cycle(st, 1'b1, rbit(), $urandom(), 1'b0, lbl);
    endtask

    // One instruction from FETCH back to FETCH. zsel: 0/1 fixed Zero, 2 random
    task automatic run_instr(input logic [31:0] instr, input int stalls, input int zsel);
        logic [5:0] op;
        logic       z;
        logic       mr;
        op = instr[31:26];
        if (stalls < 0) begin
            while ($urandom_range(0, 3) == 0)
                cycle(FETCH, 1'b0, rbit(), $urandom(), 1'b0, "fetch_wait");
        end
        cycle(FETCH, 1'b1, rbit(), $urandom(), 1'b0, "fetch");
        mr = (stalls < 0) ? rbit() : 1'b1;
        cycle(DECODE, mr, rbit(), instr, 1'b0, "decode");
        case (op)
            6'b100011: begin
                cycle(MEMADR, 1'b1, rbit(), instr, 1'b0, "lw_memadr");
                mem_wait(MEMRD, stalls, "lw_memrd");
                cycle(MEMWB, 1'b1, rbit(), $urandom(), 1'b0, "lw_memwb");
            end
            6'b101011: begin
                cycle(MEMADR, 1'b1, rbit(), instr, 1'b0, "sw_memadr");
                mem_wait(MEMWR, stalls, "sw_memwr");
            end
            6'b000000: begin
                cycle(EXEC, 1'b1, rbit(), $urandom(), 1'b0, "r_exec");
                cycle(ALUWB, 1'b1, rbit(), $urandom(), 1'b0, "r_aluwb");
            end
            6'b000100: begin
                z = (zsel == 2) ? rbit() : 1'(zsel);
                cycle(BRANCH, 1'b1, z, $urandom(), 1'b0, "beq_branch");
            end
            6'b001000: begin
                cycle(ADDIEX, 1'b1, rbit(), $urandom(), 1'b0, "addi_ex");
                cycle(ADDIWB, 1'b1, rbit(), $urandom(), 1'b0, "addi_wb");
            end
`ifdef MAIN_CTRL_JUMP_EN
            6'b000010: begin
                cycle(JUMP, 1'b1, rbit(), $urandom(), 1'b0, "j_jump");
            end
`endif
            default: ;
        endcase
    endtask

    // Monitor: one comparison per sampled cycle, plus a final drain check
    int           cyc = 0;
    logic [W-1:0] act_v;
    logic [W-1:0] exp_v;
    string        lbl_v;
    always @(negedge clk) begin
        if (mon_on) begin
            cyc++;
            act_v = {state_dbg, bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegWrite,
                     bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc,
                     bus.ALUOp, bus.PCEn, bus.IllegalOp};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL underflow cyc=%0d actual=%h required=<queued entry>", cyc, act_v);
            end else begin
                exp_v = exp_q.pop_front();
                lbl_v = lbl_q.pop_front();
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h", lbl_v, cyc, act_v, exp_v);
                end
            end
        end else if (end_req && !end_done) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL drain actual=%0d left required=0", exp_q.size());
            end
            end_done = 1'b1;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [31:0] r;
        logic [5:0]  op;
        reset           = 1'b1;
        bus.MemReady    = 1'b0;
        bus.Zero        = 1'b0;
        bus.Instruction = 32'h0;

        cycle(FETCH, 1'b0, 1'b0, 32'h0, 1'b1, "reset0");
        cycle(FETCH, 1'b1, 1'b0, 32'h0, 1'b1, "reset1");

        run_instr(32'h8C820004, 0, 2);   // lw, no waits
        run_instr(32'hAC820008, 3, 2);   // sw, three not-ready cycles
        run_instr(32'h10220003, 0, 1);   // beq taken
        run_instr(32'h10220003, 0, 0);   // beq not taken
        run_instr(32'hFC000000, 0, 2);   // unsupported opcode
        run_instr(32'h20420001, 0, 2);   // addi
        run_instr(32'h00221820, 0, 2);   // R-type

        // Reset while a store waits in MEMWR
        cycle(FETCH,  1'b1, 1'b0, $urandom(),   1'b0, "rst_fetch");
        cycle(DECODE, 1'b1, 1'b0, 32'hAC010000, 1'b0, "rst_decode");
        cycle(MEMADR, 1'b1, 1'b0, 32'hAC010000, 1'b0, "rst_memadr");
        cycle(MEMWR,  1'b0, 1'b0, $urandom(),   1'b0, "rst_memwr");
        cycle(MEMWR,  1'b0, 1'b0, $urandom(),   1'b1, "rst_in_memwr");
        cycle(FETCH,  1'b0, 1'b0, $urandom(),   1'b1, "rst_hold");

        run_instr(32'h08000010, 0, 2);   // j (legal only with jump support)

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                default: op = 6'($urandom_range(0, 63));
            endcase
            r = $urandom();
            run_instr({op, r[25:0]}, -1, 2);
        end

        @(negedge clk);
        #1;
        mon_on  = 1'b0;
        end_req = 1'b1;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
